// File: rtl/spi_responder_pkg.sv
// Shared types and defaults for the SPI mode-0 responder.
// Holds the FSM state encoding and the default word and synchronizer sizes.
package spi_responder_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam int DATA_W_DEFAULT      = 8;
  localparam int SYNC_STAGES_DEFAULT = 2;

endpackage

// File: rtl/spi_sync_edge.sv
// Brings one SPI pad into the clock domain and flags its edges.
// The edge pulses are registered one cycle after sync changes, so sync runs one cycle ahead of them; there is no backpressure.
module spi_sync_edge
  import spi_responder_pkg::*;
#(
  parameter int   STAGES  = SYNC_STAGES_DEFAULT,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  // Preset to the pad's idle level so reset release never fakes an edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      chain <= {STAGES{RST_VAL}};
      prev  <= RST_VAL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      prev  <= chain[STAGES-1];
      rise  <= chain[STAGES-1] & ~prev;
      fall  <= ~chain[STAGES-1] & prev;
    end
  end

  assign sync = chain[STAGES-1];

endmodule

// File: rtl/spi_responder.sv
// SPI mode-0 responder with a one-word transmit buffer and a held receive word.
// A received word appears SYNC_STAGES+2 cycles after the last sclk rise; an unaccepted rx word drops the new one (overrun).
module spi_responder
  import spi_responder_pkg::*;
#(
  parameter int                DATA_W      = DATA_W_DEFAULT,
  parameter int                SYNC_STAGES = SYNC_STAGES_DEFAULT,
  parameter logic [DATA_W-1:0] DEFAULT_TX  = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              spi_cs_n,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              busy,
  output logic              overrun,
  output logic              underrun,
  input  logic              flags_clr
);

  localparam int              CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  logic cs_sync_unused, cs_rise, cs_fall;
  logic sclk_sync_unused, sclk_rise, sclk_fall;
  logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clock (clock),
    .reset (reset),
    .din   (spi_cs_n),
    .sync  (cs_sync_unused),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clock (clock),
    .reset (reset),
    .din   (spi_sclk),
    .sync  (sclk_sync_unused),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi_sync (
    .clock (clock),
    .reset (reset),
    .din   (spi_mosi),
    .sync  (mosi_sync),
    .rise  (mosi_rise_unused),
    .fall  (mosi_fall_unused)
  );

  state_t            state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] tx_buf;
  logic [DATA_W-2:0] rx_shift;
  logic [DATA_W-1:0] load_word;
  logic [DATA_W-1:0] rx_word;

  // tx_ready doubles as "buffer empty": an empty buffer shifts out DEFAULT_TX.
  assign load_word = tx_ready ? DEFAULT_TX : tx_buf;
  assign rx_word   = {rx_shift, mosi_sync};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      tx_shift    <= '0;
      tx_buf      <= '0;
      rx_shift    <= '0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
      tx_ready    <= 1'b1;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      if (tx_valid && tx_ready) begin
        tx_buf   <= tx_data;
        tx_ready <= 1'b0;
      end
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      // Clear first so a set event later in this block takes priority.
      if (flags_clr) begin
        overrun  <= 1'b0;
        underrun <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (cs_fall) begin
            state       <= ACTIVE;
            busy        <= 1'b1;
            spi_miso_oe <= 1'b1;
            bit_cnt     <= '0;
            tx_shift    <= load_word;
            spi_miso    <= load_word[DATA_W-1];
            if (tx_ready) begin
              underrun <= 1'b1;
            end else begin
              tx_ready <= 1'b1;
            end
          end
        end

        ACTIVE: begin
          // Deselect wins over a simultaneous sclk edge, so a closing sclk
          // fall never consumes the next buffered word.
          if (cs_rise) begin
            state       <= IDLE;
            busy        <= 1'b0;
            spi_miso_oe <= 1'b0;
            spi_miso    <= 1'b0;
            bit_cnt     <= '0;
          end else if (sclk_rise) begin
            rx_shift <= rx_word[DATA_W-2:0];
            if (bit_cnt == LAST) begin
              bit_cnt <= '0;
              if (!rx_valid || rx_ready) begin
                rx_data  <= rx_word;
                rx_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (sclk_fall) begin
            if (bit_cnt == '0) begin
              tx_shift <= load_word;
              spi_miso <= load_word[DATA_W-1];
              if (tx_ready) begin
                underrun <= 1'b1;
              end else begin
                tx_ready <= 1'b1;
              end
            end else begin
              tx_shift <= tx_shift << 1;
              spi_miso <= tx_shift[DATA_W-2];
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_responder.sv
// Directed bench for spi_responder: a mode-0 master at f_clock/8 drives the pads,
// every comparison is an immediate assertion against hand-computed values.
module tb_spi_responder;

  logic       clock = 1'b0;
  logic       reset;
  logic       spi_cs_n, spi_sclk, spi_mosi;
  logic       spi_miso, spi_miso_oe;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;
  logic       busy, overrun, underrun, flags_clr;

  int total = 0;
  int bad   = 0;

  logic [7:0] mw [4];
  logic [7:0] mr [4];
  logic       oe_mid, busy_mid, rxv3, rxv4;
  logic [7:0] rx_q [$];

  always #5 clock = ~clock;

  spi_responder #(.DATA_W(8), .SYNC_STAGES(2), .DEFAULT_TX(8'h00)) dut (
    .clock       (clock),
    .reset       (reset),
    .spi_cs_n    (spi_cs_n),
    .spi_sclk    (spi_sclk),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .busy        (busy),
    .overrun     (overrun),
    .underrun    (underrun),
    .flags_clr   (flags_clr)
  );

  // Log every accepted rx word, sampled away from the active edge.
  always @(negedge clock) begin
    if (rx_valid && rx_ready) rx_q.push_back(rx_data);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tx_write(input logic [7:0] d);
    int n = 0;
    while (!tx_ready && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    check("tx_wr_ready", 32'(tx_ready), 32'd1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clock); #1;
    tx_valid = 1'b0;
  endtask

  task automatic pulse_rx_ready();
    rx_ready = 1'b1;
    @(posedge clock); #1;
    rx_ready = 1'b0;
  endtask

  // Mode-0 master, 4 fabric cycles per sclk half period. The transfer ends
  // with sclk fall and cs_n rise on the same cycle.
  task automatic xfer(input int nbits, input bit wr_en, input logic [7:0] wr_dat);
    logic [1:0] w;
    logic [2:0] b;
    spi_cs_n = 1'b0;
    spi_mosi = mw[0][7];
    for (int i = 0; i < nbits; i++) begin
      repeat (4) @(posedge clock);
      #1;
      if (i == 0) begin
        oe_mid   = spi_miso_oe;
        busy_mid = busy;
        if (wr_en) begin
          tx_data  = wr_dat;
          tx_valid = 1'b1;
        end
      end
      w = 2'(i / 8);
      b = 3'(7 - (i % 8));
      mr[w][b] = spi_miso;
      spi_sclk = 1'b1;
      @(posedge clock); #1;
      tx_valid = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      rxv3 = rx_valid;
      @(posedge clock); #1;
      rxv4 = rx_valid;
      spi_sclk = 1'b0;
      if (i == nbits - 1) begin
        spi_cs_n = 1'b1;
      end else begin
        w = 2'((i + 1) / 8);
        b = 3'(7 - ((i + 1) % 8));
        spi_mosi = mw[w][b];
      end
    end
    repeat (6) @(posedge clock);
    #1;
  endtask

  initial begin
    reset     = 1'b0;
    spi_cs_n  = 1'b1;
    spi_sclk  = 1'b0;
    spi_mosi  = 1'b0;
    tx_data   = '0;
    tx_valid  = 1'b0;
    rx_ready  = 1'b0;
    flags_clr = 1'b0;

    // Reset held while pins toggle
    for (int i = 0; i < 8; i++) begin
      @(posedge clock); #1;
      spi_cs_n = 1'($urandom_range(0, 1));
      spi_sclk = 1'($urandom_range(0, 1));
      spi_mosi = 1'($urandom_range(0, 1));
    end
    check("rst_miso",     32'(spi_miso),    32'd0);
    check("rst_miso_oe",  32'(spi_miso_oe), 32'd0);
    check("rst_tx_ready", 32'(tx_ready),    32'd1);
    check("rst_rx_data",  32'(rx_data),     32'h00);
    check("rst_rx_valid", 32'(rx_valid),    32'd0);
    check("rst_busy",     32'(busy),        32'd0);
    check("rst_overrun",  32'(overrun),     32'd0);
    check("rst_underrun", 32'(underrun),    32'd0);
    spi_cs_n = 1'b1;
    spi_sclk = 1'b0;
    spi_mosi = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (4) @(posedge clock);
    #1;

    // Single word: TX 0x3C, master sends 0xA5
    tx_write(8'h3C);
    check("t1_tx_full", 32'(tx_ready), 32'd0);
    mw[0] = 8'hA5;
    xfer(8, 1'b0, 8'h00);
    check("t1_miso",      32'(mr[0]),       32'h3C);
    check("t1_oe_mid",    32'(oe_mid),      32'd1);
    check("t1_busy_mid",  32'(busy_mid),    32'd1);
    check("t1_rxv_lat3",  32'(rxv3),        32'd0);
    check("t1_rxv_lat4",  32'(rxv4),        32'd1);
    check("t1_rx_data",   32'(rx_data),     32'hA5);
    check("t1_rx_held",   32'(rx_valid),    32'd1);
    check("t1_tx_ready",  32'(tx_ready),    32'd1);
    check("t1_underrun",  32'(underrun),    32'd0);
    check("t1_oe_end",    32'(spi_miso_oe), 32'd0);
    check("t1_busy_end",  32'(busy),        32'd0);
    check("t1_miso_end",  32'(spi_miso),    32'd0);
    pulse_rx_ready();
    check("t1_rx_accept", 32'(rx_valid),    32'd0);

    // Burst: 0x11 buffered, 0x22 written after the first load
    rx_q.delete();
    rx_ready = 1'b1;
    tx_write(8'h11);
    mw[0] = 8'hF0;
    mw[1] = 8'h0F;
    xfer(16, 1'b1, 8'h22);
    rx_ready = 1'b0;
    check("t2_miso0",    32'(mr[0]),      32'h11);
    check("t2_miso1",    32'(mr[1]),      32'h22);
    check("t2_rx_count", 32'(rx_q.size()), 32'd2);
    check("t2_rx0", (rx_q.size() > 0) ? 32'(rx_q[0]) : 32'hFFFF_FFFF, 32'hF0);
    check("t2_rx1", (rx_q.size() > 1) ? 32'(rx_q[1]) : 32'hFFFF_FFFF, 32'h0F);
    check("t2_underrun", 32'(underrun),   32'd0);
    check("t2_overrun",  32'(overrun),    32'd0);
    check("t2_tx_ready", 32'(tx_ready),   32'd1);

    // Underrun and overrun: empty buffer, rx_ready held low over two words
    mw[0] = 8'h96;
    mw[1] = 8'h69;
    xfer(16, 1'b0, 8'h00);
    check("t3_miso0",    32'(mr[0]),    32'h00);
    check("t3_miso1",    32'(mr[1]),    32'h00);
    check("t3_underrun", 32'(underrun), 32'd1);
    check("t3_overrun",  32'(overrun),  32'd1);
    check("t3_rx_valid", 32'(rx_valid), 32'd1);
    check("t3_rx_data",  32'(rx_data),  32'h96);
    flags_clr = 1'b1;
    @(posedge clock); #1;
    flags_clr = 1'b0;
    check("t3_clr_underrun", 32'(underrun), 32'd0);
    check("t3_clr_overrun",  32'(overrun),  32'd0);
    pulse_rx_ready();
    check("t3_rx_accept", 32'(rx_valid), 32'd0);

    // Abort after 3 bits, then a clean 0x5A transfer
    mw[0] = 8'hFF;
    xfer(3, 1'b0, 8'h00);
    check("t4_abort_rxv",  32'(rx_valid),    32'd0);
    check("t4_abort_oe",   32'(spi_miso_oe), 32'd0);
    check("t4_abort_busy", 32'(busy),        32'd0);
    mw[0] = 8'h5A;
    xfer(8, 1'b0, 8'h00);
    check("t4_rx_data",  32'(rx_data),  32'h5A);
    check("t4_rx_valid", 32'(rx_valid), 32'd1);

    // Reset after 4 bits; rx word, underrun and tx buffer left non-idle
    tx_write(8'h77);
    spi_cs_n = 1'b0;
    spi_mosi = 1'b1;
    for (int i = 0; i < 4; i++) begin
      repeat (4) @(posedge clock);
      #1;
      spi_sclk = 1'b1;
      repeat (4) @(posedge clock);
      #1;
      spi_sclk = 1'b0;
      spi_mosi = 1'($urandom_range(0, 1));
    end
    check("t5_pre_oe", 32'(spi_miso_oe), 32'd1);
    reset = 1'b0;
    #1;
    check("t5_rst_miso",     32'(spi_miso),    32'd0);
    check("t5_rst_oe",       32'(spi_miso_oe), 32'd0);
    check("t5_rst_busy",     32'(busy),        32'd0);
    check("t5_rst_tx_ready", 32'(tx_ready),    32'd1);
    check("t5_rst_rx_valid", 32'(rx_valid),    32'd0);
    check("t5_rst_rx_data",  32'(rx_data),     32'h00);
    check("t5_rst_underrun", 32'(underrun),    32'd0);
    check("t5_rst_overrun",  32'(overrun),     32'd0);
    spi_cs_n = 1'b1;
    spi_sclk = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    mw[0] = 8'hC3;
    xfer(8, 1'b0, 8'h00);
    check("t5_miso",     32'(mr[0]),    32'h00);
    check("t5_rx_data",  32'(rx_data),  32'hC3);
    check("t5_rx_valid", 32'(rx_valid), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
